// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit mux4 datapath among four requesters.
// Drives the mux4 select plus a one-hot grant; grants end on release, last, or hold timeout.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       last,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST  = TIMEOUT_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [3:0]       grant_r;
    logic [3:0]       grant_s;
    logic [1:0]       sel_r;
    logic [1:0]       sel_s;
    logic             busy_r;
    logic             busy_s;
    logic             timeout_r;
    logic             timeout_s;
    logic [1:0]       ptr_r;
    logic [1:0]       ptr_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_cnt_s;

    logic [2:0]       pick_s;
    logic             win_valid_s;
    logic [1:0]       win_idx_s;
    logic             rel_drop_s;
    logic             rel_force_s;

    // One-hot decode of a requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // First set request scanning cyclically from p; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    assign pick_s      = rr_pick(req, ptr_r);
    assign win_valid_s = pick_s[2];
    assign win_idx_s   = pick_s[1:0];
    // In GRANT, sel_r always names the current owner.
    assign rel_drop_s  = ~req[sel_r];
    assign rel_force_s = TIMEOUT_EN && (hold_cnt_r == HOLD_LAST);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        sel_s      = sel_r;
        busy_s     = busy_r;
        timeout_s  = 1'b0;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    grant_s    = onehot4(win_idx_s);
                    sel_s      = win_idx_s;
                    busy_s     = 1'b1;
                    hold_cnt_s = {CNT_W{1'b0}};
                    state_s    = ST_GRANT;
                end else begin
                    grant_s = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (hold_cnt_r < HOLD_MAX) begin
                    hold_cnt_s = hold_cnt_r + CNT_ONE;
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
                if (rel_drop_s || last || rel_force_s) begin
                    grant_s   = 4'b0000;
                    busy_s    = 1'b0;
                    ptr_s     = sel_r + 2'd1;
                    timeout_s = rel_force_s & ~rel_drop_s & ~last;
                    state_s   = ST_IDLE;
                end else begin
                    grant_s = onehot4(sel_r);
                    busy_s  = 1'b1;
                end
            end
            default: begin
                grant_s = 4'b0000;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= 4'b0000;
            sel_r      <= 2'b00;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            ptr_r      <= 2'b00;
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            sel_r      <= sel_s;
            busy_r     <= busy_s;
            timeout_r  <= timeout_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    assign grant   = grant_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=4) checked against an owner/pointer model.
module tb_mux4_rr_arbiter;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       last;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // model: owner index (-1 idle), scan pointer, cycles granted so far
    int m_owner;
    int m_ptr;
    int m_held;
    int m_sel;
    int m_to;

    mux4_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_sel   = 0;
        m_to    = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic l);
        bit found;
        bit drop;
        bit forced;
        if (m_owner < 0) begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_held  = 1;
                end
            end
        end else begin
            drop   = !r[m_owner];
            forced = (MH != 0) && (m_held == MH);
            if (drop || l || forced) begin
                m_to    = (forced && !drop && !l) ? 1 : 0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_to   = 0;
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic compare_outputs();
        int exp_grant;
        exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
        check("grant", int'(grant), exp_grant);
        check("sel", int'(sel), m_sel);
        check("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        check("timeout", int'(timeout), m_to);
        check("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    endtask

    // one clock: drive inputs, step model at the edge, compare on the falling edge
    task automatic cycle(input logic [3:0] r, input logic l);
        req  = r;
        last = l;
        @(posedge clk);
        model_edge(r, l);
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        last = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();

        // 1: reset mid-grant
        cycle(4'b0100, 1'b0);
        check("t1_grant", int'(grant), 4);
        cycle(4'b0100, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t1_rst_grant", int'(grant), 0);
        check("t1_rst_sel", int'(sel), 0);
        check("t1_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        compare_outputs();
        cycle(4'b1111, 1'b0);
        check("t1_after_rst_grant", int'(grant), 1);
        check("t1_after_rst_sel", int'(sel), 0);

        // 2: round robin with last pulsed each grant
        for (int i = 1; i <= 4; i++) begin
            cycle(4'b1111, 1'b1);
            check("t2_idle_busy", int'(busy), 0);
            cycle(4'b1111, 1'b0);
            check("t2_grant", int'(grant), 1 << (i % 4));
            check("t2_sel", int'(sel), i % 4);
        end
        cycle(4'b1111, 1'b1);
        // last while idle must be ignored
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // 3: latency and drop, ptr advances to 3
        cycle(4'b0100, 1'b0);
        check("t3_grant", int'(grant), 4);
        check("t3_sel", int'(sel), 2);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        check("t3_drop_grant", int'(grant), 0);
        check("t3_drop_sel", int'(sel), 2);
        cycle(4'b1111, 1'b0);
        check("t3_ptr3_grant", int'(grant), 8);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // 4: timeout after 4 granted cycles, then regrant
        for (int i = 0; i < MH; i++) begin
            cycle(4'b0010, 1'b0);
            check("t4_held_grant", int'(grant), 2);
        end
        cycle(4'b0010, 1'b0);
        check("t4_timeout", int'(timeout), 1);
        check("t4_released", int'(grant), 0);
        cycle(4'b0010, 1'b0);
        check("t4_regrant", int'(grant), 2);
        check("t4_timeout_clear", int'(timeout), 0);

        // 5: owner 1 forced off while requester 0 also waits
        for (int i = 1; i < MH; i++) begin
            cycle(4'b0011, 1'b0);
        end
        cycle(4'b0011, 1'b0);
        check("t5_timeout", int'(timeout), 1);
        cycle(4'b0011, 1'b0);
        check("t5_grant", int'(grant), 1);

        // 6: owner 0 releases via last while req[3] rises
        cycle(4'b1001, 1'b1);
        check("t6_idle", int'(grant), 0);
        check("t6_no_timeout", int'(timeout), 0);
        cycle(4'b1001, 1'b0);
        check("t6_grant", int'(grant), 8);
        check("t6_sel", int'(sel), 3);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
